sprite_animator: RTL and testbench

Parametrised animated-sprite renderer, the successor to the two-frame cloud block. It supports N animation frames in loop or ping-pong order, a frame-rate divider, and horizontal drift with screen wrap-around. It adds colour-key transparency and a registered hit flag that is aligned to the 1-cycle synchronous sprite ROM. It sits between the VGA scan counters (col/row) and the pixel mux, and drives the address of one external multi-frame ROM.

---
 rtl/sprite_animator_if.sv | 26 ++
 rtl/sprite_animator.sv | 122 ++++++++++++
 tb/tb_sprite_animator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_animator_if.sv
// Pixel-side bundle between the scan counters, the sprite ROM and the animator.
// No backpressure anywhere: ticks are single-cycle strobes, and rom_data answers rom_addr one clk later.
interface sprite_animator_if #(
   parameter int ADDR_W = 12
);
   logic              enable;
   logic              frame_tick;
   logic              move_tick;
   logic [9:0]        col;
   logic [9:0]        row;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_data;
   logic              is_sprite;
   logic [11:0]       sprite_rgb;
   logic [3:0]        frame_idx;

   modport master (
      output enable, frame_tick, move_tick, col, row, rom_data,
      input  rom_addr, is_sprite, sprite_rgb, frame_idx
   );

   modport slave (
      input  enable, frame_tick, move_tick, col, row, rom_data,
      output rom_addr, is_sprite, sprite_rgb, frame_idx
   );
endinterface

// File: rtl/sprite_animator.sv
// Animated sprite renderer: N-frame loop/ping-pong animation, horizontal drift with wrap,
// colour-key transparency, and a hit flag registered to line up with the synchronous ROM.
module sprite_animator #(
   parameter int          INIT_X     = 0,
   parameter int          INIT_Y     = 0,
   parameter int          SPRITE_W   = 58,
   parameter int          SPRITE_H   = 32,
   parameter int          NUM_FRAMES = 2,
   parameter int          FRAME_DIV  = 1,
   parameter bit          PINGPONG   = 1'b0,
   parameter int          STEP_X     = 1,
   parameter int          SCREEN_W   = 640,
   parameter logic [11:0] KEY_RGB    = 12'h000,
   parameter int          ADDR_W     = 12
) (
   input logic              clk,
   input logic              rst,
   sprite_animator_if.slave bus
);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   localparam logic [31:0] FRAME_PIX  = 32'(SPRITE_W * SPRITE_H);
   localparam logic [3:0]  LAST_FRAME = 4'(NUM_FRAMES - 1);
   localparam logic [7:0]  DIV_LAST   = 8'(FRAME_DIV - 1);
   localparam logic [9:0]  POS_Y      = 10'(INIT_Y);

   logic [9:0]  pos_x_q, pos_x_d;
   logic [3:0]  frame_q, frame_d;
   dir_t        dir_q, dir_d;
   logic [7:0]  div_q, div_d;
   logic        in_box_q, in_box_d;

   logic [10:0] x_end, y_end, nx;
   logic [31:0] dx, dy, addr_full;
   logic        advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_q  <= 10'(INIT_X);
         frame_q  <= 4'd0;
         dir_q    <= DIR_UP;
         div_q    <= 8'd0;
         in_box_q <= 1'b0;
      end else begin
         pos_x_q  <= pos_x_d;
         frame_q  <= frame_d;
         dir_q    <= dir_d;
         div_q    <= div_d;
         in_box_q <= in_box_d;
      end
   end

   // Hit test and ROM address; 11-bit bounds so a sprite near col 1023 cannot alias to the left.
   always_comb begin
      x_end     = {1'b0, pos_x_q} + 11'(SPRITE_W);
      y_end     = {1'b0, POS_Y} + 11'(SPRITE_H);
      in_box_d  = (bus.col >= pos_x_q) && ({1'b0, bus.col} < x_end) &&
                  (bus.row >= POS_Y)   && ({1'b0, bus.row} < y_end);
      dx        = 32'(bus.col) - 32'(pos_x_q);
      dy        = 32'(bus.row) - 32'(POS_Y);
      addr_full = 32'(frame_q) * FRAME_PIX + dy * 32'(SPRITE_W) + dx;
      bus.rom_addr = in_box_d ? addr_full[ADDR_W-1:0] : '0;
   end

   // Frame sequencer: the divider gates advances; dir only matters in ping-pong order.
   always_comb begin
      div_d   = div_q;
      frame_d = frame_q;
      dir_d   = dir_q;
      advance = 1'b0;
      if (bus.enable && bus.frame_tick) begin
         if (div_q == DIV_LAST) begin
            div_d   = 8'd0;
            advance = 1'b1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end
      if (advance) begin
         if (NUM_FRAMES == 1) begin
            frame_d = 4'd0;
         end else if (!PINGPONG) begin
            frame_d = (frame_q == LAST_FRAME) ? 4'd0 : frame_q + 4'd1;
         end else begin
            case (dir_q)
               DIR_UP: begin
                  if (frame_q == LAST_FRAME) begin
                     dir_d   = DIR_DOWN;
                     frame_d = frame_q - 4'd1;
                  end else begin
                     frame_d = frame_q + 4'd1;
                  end
               end
               default: begin
                  if (frame_q == 4'd0) begin
                     dir_d   = DIR_UP;
                     frame_d = 4'd1;
                  end else begin
                     frame_d = frame_q - 4'd1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      nx      = {1'b0, pos_x_q} + 11'(STEP_X);
      pos_x_d = pos_x_q;
      if (bus.enable && bus.move_tick) begin
         pos_x_d = (nx >= 11'(SCREEN_W)) ? 10'(nx - 11'(SCREEN_W)) : nx[9:0];
      end
   end

   always_comb begin
      bus.is_sprite  = in_box_q && (bus.rom_data != KEY_RGB);
      bus.sprite_rgb = bus.is_sprite ? bus.rom_data : 12'h000;
      bus.frame_idx  = frame_q;
   end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: three configurations share one scan/tick driver and are
// checked every negedge against a tick-count model, plus hand-computed literal points.
module tb_sprite_animator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       frame_tick = 1'b0;
   logic       move_tick = 1'b0;
   logic [9:0] col = '0;
   logic [9:0] row = '0;

   int checks = 0;
   int failures = 0;
   int ftk = 0;
   int mvs = 0;

   always #5 clk = ~clk;

   sprite_animator_if #(.ADDR_W(13)) ifa ();
   sprite_animator_if #(.ADDR_W(12)) ifb ();
   sprite_animator_if #(.ADDR_W(12)) ifc ();

   assign ifa.enable = enable;  assign ifa.frame_tick = frame_tick;  assign ifa.move_tick = move_tick;
   assign ifa.col = col;        assign ifa.row = row;
   assign ifb.enable = enable;  assign ifb.frame_tick = frame_tick;  assign ifb.move_tick = move_tick;
   assign ifb.col = col;        assign ifb.row = row;
   assign ifc.enable = enable;  assign ifc.frame_tick = frame_tick;  assign ifc.move_tick = move_tick;
   assign ifc.col = col;        assign ifc.row = row;

   // ROM models: data equals the low 12 address bits, one clk late.
   always @(posedge clk) begin
      ifa.rom_data <= ifa.rom_addr[11:0];
      ifb.rom_data <= ifb.rom_addr;
      ifc.rom_data <= ifc.rom_addr;
   end

   sprite_animator #(.INIT_X(100), .INIT_Y(50), .NUM_FRAMES(4), .FRAME_DIV(3), .ADDR_W(13))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   sprite_animator #(.NUM_FRAMES(3), .PINGPONG(1'b1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));
   sprite_animator #(.INIT_X(630), .STEP_X(7), .NUM_FRAMES(1))
      dut_c (.clk(clk), .rst(rst), .bus(ifc));

   // Model state is just the number of honoured ticks since reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ftk <= 0;
         mvs <= 0;
      end else begin
         if (enable && frame_tick) ftk <= ftk + 1;
         if (enable && move_tick)  mvs <= mvs + 1;
      end
   end

   function automatic int frame_of(input int adv, input int n, input bit pp);
      int p;
      if (n == 1) return 0;
      if (!pp) return adv % n;
      p = adv % (2 * n - 2);
      return (p < n) ? p : (2 * n - 2 - p);
   endfunction

   function automatic int pos_of(input int m, input int ix, input int step);
      return (ix + m * step) % 640;
   endfunction

   function automatic int addr_of(input int fr, input int px, input int py, input int c, input int r);
      if (c >= px && c < px + 58 && r >= py && r < py + 32)
         return fr * 1856 + (r - py) * 58 + (c - px);
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input int nfr, input bit pp, input int fdiv,
                      input int ix, input int iy, input int step, input int amask,
                      input int act_addr, input int act_frame, input int act_is, input int act_rgb,
                      input bit p_hit, input int p_rgb, output bit n_hit, output int n_rgb);
      int fr, px, a;
      bit ei;
      fr = frame_of(ftk / fdiv, nfr, pp);
      px = pos_of(mvs, ix, step);
      a  = addr_of(fr, px, iy, int'(col), int'(row));
      chk({tag, "_rom_addr"}, act_addr, (a >= 0) ? (a & amask) : 0);
      chk({tag, "_frame_idx"}, act_frame, fr);
      ei = p_hit && !rst && (p_rgb != 0);
      chk({tag, "_is_sprite"}, act_is, int'(ei));
      chk({tag, "_sprite_rgb"}, act_rgb, ei ? p_rgb : 0);
      n_hit = (a >= 0) && !rst;
      n_rgb = a & 'hfff;
   endtask

   bit pa_hit = 1'b0, pb_hit = 1'b0, pc_hit = 1'b0;
   int pa_rgb = 0, pb_rgb = 0, pc_rgb = 0;

   always @(negedge clk) begin
      cmp("A", 4, 1'b0, 3, 100, 50, 1, 'h1fff, int'(ifa.rom_addr), int'(ifa.frame_idx),
          int'(ifa.is_sprite), int'(ifa.sprite_rgb), pa_hit, pa_rgb, pa_hit, pa_rgb);
      cmp("B", 3, 1'b1, 1, 0, 0, 1, 'hfff, int'(ifb.rom_addr), int'(ifb.frame_idx),
          int'(ifb.is_sprite), int'(ifb.sprite_rgb), pb_hit, pb_rgb, pb_hit, pb_rgb);
      cmp("C", 1, 1'b0, 1, 630, 0, 7, 'hfff, int'(ifc.rom_addr), int'(ifc.frame_idx),
          int'(ifc.is_sprite), int'(ifc.sprite_rgb), pc_hit, pc_rgb, pc_hit, pc_rgb);
   end

   task automatic pix(input int c, input int r);
      @(posedge clk);
      #1;
      col = 10'(c);
      row = 10'(r);
      @(negedge clk);
   endtask

   task automatic ticks(input bit f, input bit m);
      @(posedge clk);
      #1;
      frame_tick = f;
      move_tick  = m;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      move_tick  = 1'b0;
      @(negedge clk);
   endtask

   int exp_a[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   int exp_b[7]  = '{0, 1, 2, 1, 0, 1, 2};

   initial begin
      @(negedge clk);
      chk("rst_a_frame", int'(ifa.frame_idx), 0);
      chk("rst_a_is", int'(ifa.is_sprite), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Keyed origin pixel, opaque neighbour, first column past the right edge.
      pix(100, 50);
      chk("t1_addr_origin", int'(ifa.rom_addr), 0);
      pix(101, 50);
      chk("t1_keyed_is", int'(ifa.is_sprite), 0);
      chk("t1_addr_101", int'(ifa.rom_addr), 1);
      pix(158, 50);
      chk("t1_opaque_is", int'(ifa.is_sprite), 1);
      chk("t1_opaque_rgb", int'(ifa.sprite_rgb), 1);
      chk("t1_addr_158", int'(ifa.rom_addr), 0);
      pix(157, 50);
      chk("t1_edge_is", int'(ifa.is_sprite), 0);
      chk("t1_addr_157", int'(ifa.rom_addr), 57);

      // Wrap: 630 -> 637 -> 4; the sprite at 637 is clipped at the right edge.
      pix(637, 0);
      chk("t4_c_addr_init", int'(ifc.rom_addr), 7);
      ticks(1'b0, 1'b1);
      pix(639, 0);
      chk("t4_c_addr_639", int'(ifc.rom_addr), 2);
      pix(0, 0);
      chk("t4_c_is_639", int'(ifc.is_sprite), 1);
      chk("t4_c_rgb_639", int'(ifc.sprite_rgb), 2);
      chk("t4_c_addr_0", int'(ifc.rom_addr), 0);
      pix(0, 0);
      chk("t4_c_is_0", int'(ifc.is_sprite), 0);
      ticks(1'b0, 1'b1);
      pix(5, 0);
      chk("t4_c_addr_wrapped", int'(ifc.rom_addr), 1);

      // Divided loop animation (A), ping-pong (B), single frame (C).
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("t2_a_frame_k%0d", k), int'(ifa.frame_idx), exp_a[k]);
         if (k < 7) chk($sformatf("t3_b_frame_k%0d", k), int'(ifb.frame_idx), exp_b[k]);
         chk($sformatf("t3_c_frame_k%0d", k), int'(ifc.frame_idx), 0);
         if (k == 6) begin
            pix(102, 50);
            chk("t2_a_addr_frame2", int'(ifa.rom_addr), 3712);
         end
         ticks(1'b1, 1'b0);
      end
      chk("t2_a_frame_wrap", int'(ifa.frame_idx), exp_a[12]);
      chk("t3_c_frame_end", int'(ifc.frame_idx), 0);

      // Simultaneous ticks, then the same with enable low.
      ticks(1'b1, 1'b1);
      chk("t5_b_frame_both", int'(ifb.frame_idx), 1);
      pix(104, 50);
      chk("t5_a_pos_both", int'(ifa.rom_addr), 1);
      pix(12, 0);
      chk("t5_c_pos_both", int'(ifc.rom_addr), 1);
      enable = 1'b0;
      ticks(1'b1, 1'b1);
      enable = 1'b1;
      chk("t5_b_frame_hold", int'(ifb.frame_idx), 1);
      pix(104, 50);
      chk("t5_a_pos_hold", int'(ifa.rom_addr), 1);
      pix(12, 0);
      chk("t5_c_pos_hold", int'(ifc.rom_addr), 1);

      // Async reset while A shows an opaque pixel of frame 2.
      repeat (5) ticks(1'b1, 1'b0);
      chk("t6_a_frame2", int'(ifa.frame_idx), 2);
      pix(104, 50);
      pix(104, 50);
      chk("t6_a_is_pre", int'(ifa.is_sprite), 1);
      chk("t6_a_rgb_pre", int'(ifa.sprite_rgb), 'hE81);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t6_a_is_rst", int'(ifa.is_sprite), 0);
      chk("t6_a_rgb_rst", int'(ifa.sprite_rgb), 0);
      chk("t6_a_frame_rst", int'(ifa.frame_idx), 0);
      chk("t6_a_pos_rst", int'(ifa.rom_addr), 4);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_a_is_post", int'(ifa.is_sprite), 1);
      chk("t6_a_rgb_post", int'(ifa.sprite_rgb), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
